// File: rtl/imem_resp_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH_LO = 2'd1,
    FETCH_HI = 2'd2,
    ACK      = 2'd3
  } state_t;

  // Byte-address bits below the word index.
  localparam int WORD_OFF = 2;

endpackage

// File: rtl/c2c_r.sv
// c2c_r read bus: the fetch unit is the master, the instruction memory the slave.
interface c2c_r #(
  parameter int XLEN = 32
);
  logic            re;
  logic [XLEN-1:0] addr;
  logic [3:0]      sel;
  logic [31:0]     data;
  logic            ack;

  modport master (output re, addr, sel, input data, ack);
  modport slave  (input re, addr, sel, output data, ack);
endinterface

// File: rtl/fetch_line_buf.sv
// One-word line buffer: remembers the last memory word read, with flush
// taking priority over a fill landing in the same cycle.
module fetch_line_buf #(
  parameter int TAG_W = 30
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             fill,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic [31:0]      fill_data,
  input  logic [TAG_W-1:0] lookup_tag,
  output logic             hit,
  output logic [31:0]      buf_data
);

  logic             valid;
  logic [TAG_W-1:0] tag;

  // Valid bit: flush beats fill.
  always_ff @(posedge clk) begin
    if (reset)      valid <= 1'b0;
    else if (flush) valid <= 1'b0;
    else if (fill)  valid <= 1'b1;
  end

  // Tag and data payload.
  // NOTE: payload is not reset; it is only ever consumed when valid is set.
  always_ff @(posedge clk) begin
    if (fill && !flush) begin
      tag      <= fill_tag;
      buf_data <= fill_data;
    end
  end

  assign hit = valid && (tag == lookup_tag);

endmodule

// File: rtl/imem_responder.sv
// Responder end of c2c_r serving halfword-aligned 32-bit instruction fetch
// windows; straddling windows are assembled from two word reads.
module imem_responder
  import imem_resp_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  c2c_r.slave                      instr_bus,
  input  logic                     flush,
  output logic                     mem_req,
  output logic [XLEN-WORD_OFF-1:0] mem_addr,
  input  logic [31:0]              mem_rdata,
  input  logic                     mem_rvalid
);

  localparam int WW = XLEN - WORD_OFF;

  state_t        state, state_next;
  logic [XLEN-2:0] req_addr;      // request address without the ignored bit 0
  logic [WW-1:0] w0, w1;
  logic [31:0]   lo, result, data_hold;
  logic          aborted, flush_seen;

  logic          latch_req, lo_en, res_en, fill, ack_c;
  logic [31:0]   lo_next, res_next;
  logic [WW-1:0] fill_tag;
  logic          hit;
  logic [31:0]   buf_data;

  logic [WW-1:0] bus_word;
  logic          bus_half, half, abort_now, unused_bits;

  assign bus_word    = instr_bus.addr[XLEN-1:WORD_OFF];
  assign bus_half    = instr_bus.addr[1];
  assign half        = req_addr[0];
  assign abort_now   = aborted || !instr_bus.re || (instr_bus.addr[XLEN-1:1] != req_addr);
  assign unused_bits = ^{instr_bus.sel, instr_bus.addr[0]};

  fetch_line_buf #(.TAG_W(WW)) u_buf (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .fill       (fill && !flush_seen),
    .fill_tag   (fill_tag),
    .fill_data  (mem_rdata),
    .lookup_tag (bus_word),
    .hit        (hit),
    .buf_data   (buf_data)
  );

  // Next-state, memory request and datapath enables.
  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    latch_req  = 1'b0;
    lo_en      = 1'b0;
    lo_next    = buf_data;
    res_en     = 1'b0;
    res_next   = buf_data;
    fill       = 1'b0;
    fill_tag   = w0;
    ack_c      = 1'b0;
    mem_req    = 1'b0;
    mem_addr   = '0;
    unique case (state)
      IDLE: begin
        if (instr_bus.re) begin
          latch_req = 1'b1;
          if (hit && !bus_half) begin
            res_en     = 1'b1;
            state_next = ACK;
          end else if (hit) begin
            lo_en      = 1'b1;
            state_next = FETCH_HI;
          end else begin
            state_next = FETCH_LO;
          end
        end
      end
      FETCH_LO: begin
        mem_req  = 1'b1;
        mem_addr = w0;
        if (mem_rvalid) begin
          fill = 1'b1;
          if (abort_now) begin
            state_next = IDLE;
          end else if (!half) begin
            res_en     = 1'b1;
            res_next   = mem_rdata;
            state_next = ACK;
          end else begin
            lo_en      = 1'b1;
            lo_next    = mem_rdata;
            state_next = FETCH_HI;
          end
        end
      end
      FETCH_HI: begin
        mem_req  = 1'b1;
        mem_addr = w1;
        fill_tag = w1;
        if (mem_rvalid) begin
          fill = 1'b1;
          if (abort_now) begin
            state_next = IDLE;
          end else begin
            res_en     = 1'b1;
            res_next   = {mem_rdata[15:0], lo[31:16]};
            state_next = ACK;
          end
        end
      end
      ACK: begin
        ack_c      = instr_bus.re && (instr_bus.addr[XLEN-1:1] == req_addr);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      req_addr   <= '0;
      w0         <= '0;
      w1         <= '0;
      lo         <= '0;
      result     <= '0;
      data_hold  <= '0;
      aborted    <= 1'b0;
      flush_seen <= 1'b0;
    end else begin
      state <= state_next;
      if (latch_req) begin
        req_addr <= instr_bus.addr[XLEN-1:1];
        w0       <= bus_word;
        w1       <= bus_word + WW'(1);
      end
      if (lo_en)  lo <= lo_next;
      if (res_en) result <= res_next;
      if (ack_c)  data_hold <= result;
      // Once aborted, the request stays aborted until the read drains.
      aborted    <= (state == FETCH_LO || state == FETCH_HI) && abort_now;
      // A flush blocks every later fill of the request in flight.
      flush_seen <= flush || (flush_seen && state != IDLE);
    end
  end

  assign instr_bus.ack  = ack_c;
  assign instr_bus.data = ack_c ? result : data_hold;

endmodule

// File: tb/tb_imem_responder.sv
// Randomised bench for imem_responder against a word-level fetch model.
module tb_imem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        mem_req;
  logic [29:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;

  c2c_r #(.XLEN(32)) bus ();

  imem_responder #(.XLEN(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .instr_bus  (bus),
    .flush      (flush),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Memory contents and read log.
  int          mem_lat = 1;
  logic [29:0] reads[$];
  logic [29:0] exp_reads[$];

  function automatic logic [31:0] mem_word(input logic [29:0] idx);
    return 32'hA000_0000 | {2'b00, idx};
  endfunction

  // Word memory: one outstanding read, mem_lat cycles after the request.
  initial begin
    bit          busy = 1'b0;
    int          cnt = 0;
    logic [29:0] cap = '0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_rvalid = 1'b0;
      if (busy) begin
        cnt--;
        if (cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem_word(cap);
          busy       = 1'b0;
        end
      end else if (mem_req) begin
        busy = 1'b1;
        cnt  = mem_lat;
        cap  = mem_addr;
        reads.push_back(mem_addr);
      end
    end
  end

  // Reference: a one-word buffer holding the last word read from memory.
  bit          ref_valid = 1'b0;
  logic [29:0] ref_tag   = '0;

  task automatic ref_fetch(input logic [31:0] a, output logic [31:0] d, output int lat);
    logic [29:0] wa, wb;
    logic [31:0] lo_w, hi_w;
    wa = a[31:2];
    wb = wa + 30'd1;
    lo_w = mem_word(wa);
    hi_w = mem_word(wb);
    exp_reads.delete();
    if (!a[1]) begin
      if (!(ref_valid && ref_tag == wa)) begin
        exp_reads.push_back(wa);
        ref_valid = 1'b1;
        ref_tag   = wa;
      end
      d = lo_w;
    end else begin
      if (!(ref_valid && ref_tag == wa)) exp_reads.push_back(wa);
      exp_reads.push_back(wb);
      ref_valid = 1'b1;
      ref_tag   = wb;
      d = {hi_w[15:0], lo_w[31:16]};
    end
    lat = 1 + exp_reads.size() * (mem_lat + 1);
  endtask

  function automatic bit reads_match();
    if (reads.size() != exp_reads.size()) return 1'b0;
    foreach (reads[i]) if (reads[i] !== exp_reads[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [29:0] first_or_zero(input logic [29:0] q[$]);
    return (q.size() > 0) ? q[0] : 30'h0;
  endfunction

  // Issue one fetch and wait (bounded) for its ack.
  task automatic do_fetch(input logic [31:0] a, input bit flush_on_rvalid,
                          output logic [31:0] d, output int lat, output bit got);
    bit armed;
    armed = flush_on_rvalid;
    got = 1'b0;
    lat = -1;
    d = '0;
    reads.delete();
    @(posedge clk);
    #1;
    bus.re   = 1'b1;
    bus.addr = a;
    bus.sel  = 4'($urandom);
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      flush = 1'b0;
      if (bus.ack) begin
        got = 1'b1;
        lat = n;
        d   = bus.data;
      end else if (armed && mem_rvalid) begin
        flush = 1'b1;
        armed = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    bus.re = 1'b0;
    flush  = 1'b0;
  endtask

  task automatic flush_pulse();
    @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    ref_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    flush = 1'b0;
    bus.re = 1'b0;
    bus.addr = '0;
    bus.sel = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({bus.ack, bus.data, mem_req, mem_addr} !== 64'h0) begin
      n_err++;
      $display("FAIL reset_values: ack=%b data=%h mem_req=%b mem_addr=%h, want all 0",
               bus.ack, bus.data, mem_req, mem_addr);
    end
    #1 reset = 1'b0;
    ref_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.ack, mem_req} !== 2'b00) begin
      n_err++;
      $display("FAIL idle_after_reset: ack=%b mem_req=%b, want 0 0", bus.ack, mem_req);
    end
  endtask

  // Directed fetch with full comparison of data, reads and latency.
  task automatic test_fetch(input string name, input logic [31:0] a, input int lat_mem);
    logic [31:0] d, ed;
    int lat, elat;
    bit got;
    mem_lat = lat_mem;
    ref_fetch(a, ed, elat);
    do_fetch(a, 1'b0, d, lat, got);
    n_cmp++;
    if (!got || d !== ed) begin
      n_err++;
      $display("FAIL %s data: got=%b data=%h, want %h", name, got, d, ed);
    end
    n_cmp++;
    if (!reads_match()) begin
      n_err++;
      $display("FAIL %s reads: %0d reads first=%h, want %0d first=%h", name,
               reads.size(), first_or_zero(reads), exp_reads.size(), first_or_zero(exp_reads));
    end
    n_cmp++;
    if (lat !== elat) begin
      n_err++;
      $display("FAIL %s latency: %0d, want %0d", name, lat, elat);
    end
  endtask

  task automatic test_aligned();
    test_fetch("aligned_miss", 32'h0000_0100, 1);
    test_fetch("aligned_hit", 32'h0000_0100, 1);
  endtask

  task automatic test_straddle();
    test_fetch("straddle_hit_lo", 32'h0000_0102, 1);
    test_fetch("straddle_seq", 32'h0000_0106, 1);
    test_fetch("straddle_miss", 32'h0000_0702, 2);
  endtask

  task automatic test_wrap();
    flush_pulse();
    test_fetch("wrap_top", 32'hFFFF_FFFE, 1);
  endtask

  task automatic test_abort();
    logic [31:0] d, ed;
    int elat;
    bit got, early;
    flush_pulse();
    mem_lat = 5;
    reads.delete();
    early = 1'b0;
    got = 1'b0;
    d = '0;
    @(posedge clk);
    #1;
    bus.re = 1'b1;
    bus.addr = 32'h0000_0200;
    repeat (2) begin
      @(negedge clk);
      if (bus.ack) early = 1'b1;
    end
    @(posedge clk);
    #1 bus.addr = 32'h0000_0300;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (bus.ack) begin
        got = 1'b1;
        d = bus.data;
      end
    end
    @(posedge clk);
    #1 bus.re = 1'b0;
    // The aborted read still fills the buffer before the new request.
    ref_valid = 1'b1;
    ref_tag = 30'h80;
    ref_fetch(32'h0000_0300, ed, elat);
    exp_reads.push_front(30'h80);
    n_cmp++;
    if (early) begin
      n_err++;
      $display("FAIL abort_no_ack: ack seen for 0x200, want none");
    end
    n_cmp++;
    if (!got || d !== ed) begin
      n_err++;
      $display("FAIL abort_data: got=%b data=%h, want %h", got, d, ed);
    end
    n_cmp++;
    if (!reads_match()) begin
      n_err++;
      $display("FAIL abort_reads: %0d reads first=%h, want %0d first=%h",
               reads.size(), first_or_zero(reads), exp_reads.size(), first_or_zero(exp_reads));
    end
  endtask

  task automatic test_flush();
    logic [31:0] d, ed;
    int lat, elat;
    bit got;
    mem_lat = 1;
    ref_fetch(32'h0000_0104, ed, elat);
    do_fetch(32'h0000_0104, 1'b1, d, lat, got);
    ref_valid = 1'b0;
    n_cmp++;
    if (!got || d !== ed) begin
      n_err++;
      $display("FAIL flush_data: got=%b data=%h, want %h", got, d, ed);
    end
    test_fetch("flush_refetch", 32'h0000_0104, 1);
  endtask

  task automatic test_reset_mid();
    bit found;
    found = 1'b0;
    mem_lat = 5;
    @(posedge clk);
    #1;
    bus.re = 1'b1;
    bus.addr = 32'h0000_0402;
    for (int n = 0; n < 100 && !found; n++) begin
      @(negedge clk);
      if (mem_req && mem_addr == 30'h101) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL reset_mid_reach_hi: mem_addr=%h, want 101", mem_addr);
    end
    reset = 1'b1;
    bus.re = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.ack, mem_req, bus.data} !== 34'h0) begin
      n_err++;
      $display("FAIL reset_mid_outputs: ack=%b mem_req=%b data=%h, want 0 0 0",
               bus.ack, mem_req, bus.data);
    end
    reset = 1'b0;
    ref_valid = 1'b0;
    repeat (10) @(posedge clk);
    test_fetch("reset_mid_refetch", 32'h0000_0402, 1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) flush_pulse();
      test_fetch("random", 32'h0000_1000 + 32'($urandom_range(0, 15)) * 2,
                 int'($urandom_range(1, 4)));
    end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_straddle();
    test_wrap();
    test_abort();
    test_flush();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
